seq_gen_tx: RTL and testbench
=============================

// Module: seq_gen_tx
// PURPOSE
//  Serial pattern transmitter: loads a WIDTH-bit pattern and shifts it out MSB-first on X,
//  one bit per DIV clocks, with a one-cycle en strobe marking each valid bit.
//  Transmit side of the X/en serial interface; drives the X/en inputs of the Mealy sequence
//  detector for stimulus and on-chip pattern injection. One bit stream in flight at a time.
// PARAMETERS
//  WIDTH  8  max pattern length in bits (>=2)
//  DIV    4  clocks per bit period (>=1); en asserted once per period
//  LW     $clog2(WIDTH+1)  localparam, width of len
// PORTS
//  clk      in   1      clock, rising edge
//  rst_n    in   1      reset, asynchronous, active-low
//  start    in   1      transfer request; accepted only in IDLE
//  pattern  in   WIDTH  data, sampled on accepted start; pattern[WIDTH-1] sent first
//  len      in   LW     bits to send, sampled with pattern; 0 = no bits; >WIDTH clamped to WIDTH
//  X        out  1      serial data, held stable for the whole bit period
//  en       out  1      bit-valid strobe, one cycle per bit, at end of bit period
//  busy     out  1      high whenever state != IDLE
//  done     out  1      one-cycle pulse, transfer complete
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, X=0, en=0, busy=0, done=0, shift reg/counters cleared.
//  - States: IDLE -> SHIFT -> [PAR] -> DONE -> IDLE.
//    IDLE:  start=1 at edge: load shreg<=pattern, bit_cnt<=min(len,WIDTH), div_cnt<=0;
//           bit_cnt==0 -> DONE, else SHIFT. start=0: stay.
//    SHIFT: X=shreg[WIDTH-1]; div_cnt counts 0..DIV-1, wraps to 0; en=(div_cnt==DIV-1).
//           On en: shreg<<=1, bit_cnt--; if bit_cnt was 1 -> PAR (macro on) or DONE.
//    PAR:   one bit period, X=parity, en at div_cnt==DIV-1, then DONE.
//    DONE:  done=1 for exactly one cycle, X=0, then IDLE.
//  - Timing (start high in cycle 0): bit i strobed in cycle (i+1)*DIV; done in cycle len*DIV+1
//    (+DIV with parity); busy high cycles 1..done cycle inclusive; back in IDLE next cycle.
//  - DIV=1: en high every SHIFT cycle, one bit per clock.
//  - start while busy (incl. DONE cycle): ignored, not queued; pattern/len changes ignored.
//  - X=0 and en=0 in IDLE and DONE; en never high outside SHIFT/PAR.
//  - rst_n low mid-transfer: abort immediately, no done pulse, no further en.
//  - Back-to-back: start in first IDLE cycle after DONE accepted normally.
// CONFIGURATION
//  SEQ_GEN_TX_PARITY_EN defined: PAR state compiled in; after last data bit one extra bit
//  sent, X = XOR of the len transmitted bits (even parity); len=0 sends no parity bit.
//  Undefined: PAR state and parity logic absent; SHIFT goes straight to DONE.
// STRUCTURE
//  Package seq_pkg: typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_PAR, TX_DONE} tx_state_t;
//  shared with the detector's state typedef and any common X/en interface constants.
//  Sub-module seq_bit_timer: DIV-period counter, inputs clk/rst_n/run, output strobe (en).
//  Top holds FSM, shift reg, bit counter, parity accumulator.
// TESTING (WIDTH=8, DIV=4 unless stated; start in cycle 0)
//  1 pattern=8'hB2,len=8 -> en in cycles 4,8,..,32; X at strobes 1,0,1,1,0,0,1,0; done cycle 33.
//  2 pattern=8'hC0,len=3 -> X=1,1,0 at cycles 4,8,12; done cycle 13; len=0 -> done cycle 1, no en.
//  3 start re-asserted cycle 10 with pattern=8'hFF -> ignored; stream still 8'hB2, 8 strobes.
//  4 rst_n low in cycle 15 -> X,en,busy,done=0 at once; no done; new start after release OK.
//  5 DIV=1, pattern=8'hA5,len=8 -> en high cycles 1..8, X=1,0,1,0,0,1,0,1; done cycle 9.
//  6 PARITY_EN: 8'hB2 -> 9th strobe cycle 36 X=0, done 37; 8'h01 -> parity X=1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the X/en serial interface (pattern
// transmitter and Mealy sequence detector).
package seq_pkg;

    // Transmitter FSM states; TX_PAR is only reachable when parity is compiled in
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SHIFT = 2'd1,
        TX_PAR   = 2'd2,
        TX_DONE  = 2'd3
    } tx_state_t;

    // Level driven on X whenever no bit is being presented
    localparam logic X_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/seq_bit_timer.sv
// Bit-period timer: counts DIV clocks while run is high and raises strobe
// on the last clock of each period. Held at zero whenever run is low so
// every transfer starts on a fresh period.
module seq_bit_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic strobe
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    // Period counter: wraps at DIV-1 so consecutive bits share one timebase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!run) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    assign strobe = run && (div_cnt == LAST);

endmodule

// File: rtl/seq_gen_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out MSB-first on X,
// one bit per DIV clocks, with a one-cycle en strobe at the end of each bit.
// Optional feature macro: SEQ_GEN_TX_PARITY_EN appends an even-parity bit
// after the last data bit (not sent for len=0).
module seq_gen_tx
    import seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DIV   = 4,
    localparam int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    output logic             X,
    output logic             en,
    output logic             busy,
    output logic             done
);

    tx_state_t        state;
    tx_state_t        state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [LW-1:0]    bit_cnt;
    logic [LW-1:0]    len_clamped;
    logic             last_bit;
    logic             run;
    logic             strobe;
`ifdef SEQ_GEN_TX_PARITY_EN
    logic             parity;
`endif

    // Requests longer than the shift register send the whole register
    assign len_clamped = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
    assign last_bit    = (bit_cnt == LW'(1));

    seq_bit_timer #(
        .DIV (DIV)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .strobe (strobe)
    );

    assign en = strobe;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so requests while busy are dropped
    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE: begin
                if (start) begin
                    state_nxt = (len_clamped == '0) ? TX_DONE : TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (strobe && last_bit) begin
`ifdef SEQ_GEN_TX_PARITY_EN
                    state_nxt = TX_PAR;
`else
                    state_nxt = TX_DONE;
`endif
                end
            end
            TX_PAR: begin
`ifdef SEQ_GEN_TX_PARITY_EN
                if (strobe) begin
                    state_nxt = TX_DONE;
                end
`else
                state_nxt = TX_IDLE;
`endif
            end
            TX_DONE: state_nxt = TX_IDLE;
            default: state_nxt = TX_IDLE;
        endcase
    end

    // Output decode: X presents the current bit for the whole period, zero otherwise
    always_comb begin
        X    = X_IDLE_LEVEL;
        run  = 1'b0;
        busy = (state != TX_IDLE);
        done = (state == TX_DONE);
        case (state)
            TX_SHIFT: begin
                X   = shreg[WIDTH-1];
                run = 1'b1;
            end
`ifdef SEQ_GEN_TX_PARITY_EN
            TX_PAR: begin
                X   = parity;
                run = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Datapath: load on an accepted start, advance one bit on each strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
`ifdef SEQ_GEN_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            case (state)
                TX_IDLE: begin
                    if (start) begin
                        shreg   <= pattern;
                        bit_cnt <= len_clamped;
`ifdef SEQ_GEN_TX_PARITY_EN
                        parity  <= 1'b0;
`endif
                    end
                end
                TX_SHIFT: begin
                    if (strobe) begin
                        shreg   <= {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt - LW'(1);
`ifdef SEQ_GEN_TX_PARITY_EN
                        parity  <= parity ^ shreg[WIDTH-1];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_tx.sv
// Testbench for seq_gen_tx: one DIV=4 instance and one DIV=1 instance, each
// checked cycle by cycle against a per-cycle model built from the bit list.
// Honours SEQ_GEN_TX_PARITY_EN in the model.
module tb_seq_gen_tx;

    localparam int WIDTH = 8;
    localparam int LW    = $clog2(WIDTH + 1);
    localparam int MAXC  = 64;
`ifdef SEQ_GEN_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_a, start_b;
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0]    len;
    logic             x_a, en_a, busy_a, done_a;
    logic             x_b, en_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    // {x, en, busy, done} per cycle, observed and expected
    logic [3:0] obs   [0:MAXC-1];
    logic [3:0] exp_v [0:MAXC-1];
    int         exp_done_cyc;

    always #5 clk = ~clk;

    seq_gen_tx #(.WIDTH(WIDTH), .DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .pattern(pattern), .len(len),
        .X(x_a), .en(en_a), .busy(busy_a), .done(done_a)
    );

    seq_gen_tx #(.WIDTH(WIDTH), .DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .pattern(pattern), .len(len),
        .X(x_b), .en(en_b), .busy(busy_b), .done(done_b)
    );

    // Reference model: list the bits to send, then lay them out over time
    task automatic model_tx(input logic [WIDTH-1:0] pat, input int ln, input int div);
        bit bits[$];
        int n;
        bit p;
        n = (ln > WIDTH) ? WIDTH : ln;
        p = 1'b0;
        for (int k = 0; k < n; k++) begin
            bits.push_back(pat[WIDTH-1-k]);
            p = p ^ pat[WIDTH-1-k];
        end
        if (PAR && n > 0) bits.push_back(p);
        exp_done_cyc = bits.size() * div + 1;
        for (int c = 0; c < MAXC; c++) begin
            exp_v[c] = 4'b0000;
            if (c >= 1 && c < exp_done_cyc) begin
                exp_v[c][3] = bits[(c - 1) / div];
                exp_v[c][2] = ((c % div) == 0);
                exp_v[c][1] = 1'b1;
            end else if (c == exp_done_cyc) begin
                exp_v[c] = 4'b0011;
            end
        end
    endtask

    // Drive start in cycle 0, scramble inputs afterwards, sample every cycle at negedge
    task automatic run_tx(input bit sel, input logic [WIDTH-1:0] pat, input logic [LW-1:0] ln,
                          input int ncyc, input int re_cyc, input logic [WIDTH-1:0] re_pat,
                          input int abort_cyc);
        @(posedge clk); #1;
        pattern = pat;
        len     = ln;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        for (int c = 0; c <= ncyc; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                start_a = 1'b0;
                start_b = 1'b0;
                pattern = WIDTH'($urandom);
                len     = LW'($urandom);
                if (c == re_cyc) begin
                    pattern = re_pat;
                    len     = LW'(WIDTH);
                    if (sel) start_b = 1'b1; else start_a = 1'b1;
                end
                if (c == abort_cyc) rst_n = 1'b0;
            end
            @(negedge clk);
            obs[c] = sel ? {x_b, en_b, busy_b, done_b} : {x_a, en_a, busy_a, done_a};
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        pattern = '0;
        len     = '0;
        #2 rst_n = 1'b0;
        #2;
        checks++;
        if ({x_a, en_a, busy_a, done_a} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async_a: got %b required 0000", {x_a, en_a, busy_a, done_a});
        end
        checks++;
        if ({x_b, en_b, busy_b, done_b} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async_b: got %b required 0000", {x_b, en_b, busy_b, done_b});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({x_a, en_a, busy_a, done_a, x_b, en_b, busy_b, done_b} !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: got %b required 00000000",
                     {x_a, en_a, busy_a, done_a, x_b, en_b, busy_b, done_b});
        end
    endtask

    task automatic test_streams();
        logic [WIDTH-1:0] pats [10] = '{8'hB2, 8'hC0, 8'h3C, 8'h5A, 8'h01, 8'hFF, 8'h80, 8'h00, 8'h7E, 8'h96};
        int               lens [10] = '{8, 3, 0, 12, 8, 1, 15, 8, 9, 2};
        logic [WIDTH-1:0] p;
        int               l;
        for (int t = 0; t < 18; t++) begin
            if (t < 10) begin
                p = pats[t];
                l = lens[t];
            end else begin
                p = WIDTH'($urandom);
                l = $urandom_range(0, 15);
            end
            model_tx(p, l, 4);
            run_tx(1'b0, p, LW'(l), exp_done_cyc + 2, -1, '0, -1);
            for (int c = 0; c <= exp_done_cyc + 2; c++) begin
                checks++;
                if (obs[c] !== exp_v[c]) begin
                    errors++;
                    $display("FAIL stream pat=%h len=%0d cyc=%0d: x,en,busy,done=%b required %b",
                             p, l, c, obs[c], exp_v[c]);
                end
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [WIDTH-1:0] p;
        int               l;
        int               re;
        for (int t = 0; t < 3; t++) begin
            p = (t == 0) ? 8'hB2 : WIDTH'($urandom);
            l = (t == 0) ? 8 : $urandom_range(1, 8);
            model_tx(p, l, 4);
            // Re-request mid-transfer, then exactly in the DONE cycle
            re = (t == 0) ? 10 : exp_done_cyc;
            run_tx(1'b0, p, LW'(l), exp_done_cyc + 3, re, 8'hFF, -1);
            for (int c = 0; c <= exp_done_cyc + 3; c++) begin
                checks++;
                if (obs[c] !== exp_v[c]) begin
                    errors++;
                    $display("FAIL ignore_start pat=%h restart=%0d cyc=%0d: x,en,busy,done=%b required %b",
                             p, re, c, obs[c], exp_v[c]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] p;
        int               l;
        for (int t = 0; t < 4; t++) begin
            p = WIDTH'($urandom);
            l = (t == 1) ? 0 : $urandom_range(1, 8);
            model_tx(p, l, 4);
            // Ending exactly on the done cycle puts the next start in the first IDLE cycle
            run_tx(1'b0, p, LW'(l), exp_done_cyc, -1, '0, -1);
            for (int c = 0; c <= exp_done_cyc; c++) begin
                checks++;
                if (obs[c] !== exp_v[c]) begin
                    errors++;
                    $display("FAIL back_to_back #%0d pat=%h len=%0d cyc=%0d: x,en,busy,done=%b required %b",
                             t, p, l, c, obs[c], exp_v[c]);
                end
            end
        end
    endtask

    task automatic test_abort();
        model_tx(8'hB2, 8, 4);
        for (int c = 15; c < MAXC; c++) exp_v[c] = 4'b0000;
        run_tx(1'b0, 8'hB2, LW'(8), 22, -1, '0, 15);
        for (int c = 0; c <= 22; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin
                errors++;
                $display("FAIL abort cyc=%0d: x,en,busy,done=%b required %b", c, obs[c], exp_v[c]);
            end
        end
        @(posedge clk); #1 rst_n = 1'b1;
        model_tx(8'hC0, 3, 4);
        run_tx(1'b0, 8'hC0, LW'(3), exp_done_cyc + 2, -1, '0, -1);
        for (int c = 0; c <= exp_done_cyc + 2; c++) begin
            checks++;
            if (obs[c] !== exp_v[c]) begin
                errors++;
                $display("FAIL after_abort cyc=%0d: x,en,busy,done=%b required %b", c, obs[c], exp_v[c]);
            end
        end
    endtask

    task automatic test_div1();
        logic [WIDTH-1:0] p;
        int               l;
        for (int t = 0; t < 4; t++) begin
            p = (t == 0) ? 8'hA5 : WIDTH'($urandom);
            l = (t == 0) ? 8 : $urandom_range(0, 15);
            model_tx(p, l, 1);
            run_tx(1'b1, p, LW'(l), exp_done_cyc + 2, -1, '0, -1);
            for (int c = 0; c <= exp_done_cyc + 2; c++) begin
                checks++;
                if (obs[c] !== exp_v[c]) begin
                    errors++;
                    $display("FAIL div1 pat=%h len=%0d cyc=%0d: x,en,busy,done=%b required %b",
                             p, l, c, obs[c], exp_v[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_streams();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_div1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
